ultrasound_range_collector: RTL and testbench



---
 rtl/ultrasound_range_collector_pkg.sv | 19 +
 rtl/ultrasound_range_collector_echo_sync_edge.sv | 33 +++
 rtl/ultrasound_range_collector.sv | 186 ++++++++++++++++++
 tb/tb_ultrasound_range_collector.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasound_range_collector_pkg.sv
// Shared constants and FSM state encoding for the ultrasound range collector.
package ultrasound_range_collector_pkg;

  localparam int unsigned NUM_CH_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CH_W       = 3;
  localparam logic [DATA_W_DEF-1:0] RANGE_SAT = {DATA_W_DEF{1'b1}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIGGER   = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    STORE     = 3'd4,
    GAP       = 3'd5,
    DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/ultrasound_range_collector_echo_sync_edge.sv
// Two-flop synchronizer for the asynchronous echo input with registered
// single-cycle rise/fall pulses derived from the synchronized level.
module ultrasound_range_collector_echo_sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic echo_in,
  output logic rise,
  output logic fall
);

  logic meta_r, sync_r, prev_r, rise_r, fall_r;

  // synchronizer chain and edge detection on the synchronized level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      meta_r <= echo_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
      rise_r <= sync_r & ~prev_r;
      fall_r <= ~sync_r & prev_r;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/ultrasound_range_collector.sv
// Sequential 5-channel ultrasound scanner: trigger, time echo, saturate, store.
// Optional RANGE_MIN_TRACK_EN adds min_index (lowest reading, lower index on tie).
module ultrasound_range_collector
  import ultrasound_range_collector_pkg::*;
#(
  parameter int unsigned NUM_CH      = NUM_CH_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TICK_DIV    = 64,
  parameter int unsigned TRIG_CYCLES = 270,
  parameter int unsigned GAP_CYCLES  = 1024
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     echo_in,
  output logic [NUM_CH-1:0]        trigger_out,
  output logic [CH_W-1:0]          ch_sel,
  output logic [NUM_CH*DATA_W-1:0] values,
  output logic                     busy,
  output logic                     done
`ifdef RANGE_MIN_TRACK_EN
  ,
  output logic [CH_W-1:0]          min_index
`endif
);

  localparam int unsigned TMR_MAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned PSC_W   = $clog2(TICK_DIV);
  localparam logic [DATA_W-1:0] SAT = {DATA_W{1'b1}};

  state_t                   state_r, state_s;
  logic [CH_W-1:0]          ch_r, ch_s;
  logic [TMR_W-1:0]         tmr_r;
  logic [PSC_W-1:0]         psc_r;
  logic [DATA_W-1:0]        cnt_r;
  logic [NUM_CH-1:0]        trig_s;
  logic                     rise_s, fall_s;
  logic [NUM_CH-1:0]        trigger_out_r;
  logic [CH_W-1:0]          ch_sel_r;
  logic [NUM_CH*DATA_W-1:0] values_r;
  logic                     busy_r, done_r;

  ultrasound_range_collector_echo_sync_edge u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .echo_in (echo_in),
    .rise    (rise_s),
    .fall    (fall_s)
  );

  // next-state, next-channel and next trigger pattern
  always_comb begin
    state_s = state_r;
    ch_s    = ch_r;
    trig_s  = '0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = TRIGGER;
          ch_s    = CH_W'(1);
        end else begin
          ch_s    = '0;
        end
      end
      TRIGGER: begin
        if (tmr_r == TMR_W'(TRIG_CYCLES - 1)) state_s = WAIT_RISE;
        else                                  state_s = TRIGGER;
      end
      WAIT_RISE: begin
        if (rise_s)           state_s = MEASURE;
        else if (cnt_r == SAT) state_s = STORE;
        else                   state_s = WAIT_RISE;
      end
      MEASURE: begin
        if (fall_s || cnt_r == SAT) state_s = STORE;
        else                        state_s = MEASURE;
      end
      STORE: begin
        if (ch_r < CH_W'(NUM_CH)) state_s = GAP;
        else                      state_s = DONE;
      end
      GAP: begin
        if (tmr_r == TMR_W'(GAP_CYCLES - 1)) begin
          state_s = TRIGGER;
          ch_s    = ch_r + CH_W'(1);
        end else begin
          state_s = GAP;
        end
      end
      DONE: begin
        state_s = IDLE;
        ch_s    = '0;
      end
      default: begin
        state_s = IDLE;
        ch_s    = '0;
      end
    endcase
    if (state_s == TRIGGER) begin
      for (int k = 0; k < int'(NUM_CH); k++) trig_s[k] = (ch_s == CH_W'(k + 1));
    end else begin
      trig_s = '0;
    end
  end

  // state, channel and phase timer; the timer restarts on every state change
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      ch_r    <= '0;
      tmr_r   <= '0;
    end else begin
      state_r <= state_s;
      ch_r    <= ch_s;
      tmr_r   <= (state_s != state_r) ? '0 : tmr_r + TMR_W'(1);
    end
  end

  // range counter: cleared in TRIGGER and on the echo rise, saturating, never wraps
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      psc_r <= '0;
      cnt_r <= '0;
    end else if (state_r == TRIGGER || (state_r == WAIT_RISE && rise_s)) begin
      psc_r <= '0;
      cnt_r <= '0;
    end else if (state_r == WAIT_RISE || state_r == MEASURE) begin
      if (psc_r == PSC_W'(TICK_DIV - 1)) begin
        psc_r <= '0;
        if (cnt_r != SAT) cnt_r <= cnt_r + DATA_W'(1);
      end else begin
        psc_r <= psc_r + PSC_W'(1);
      end
    end
  end

  // reading store (only the active slot) and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      values_r      <= '0;
      trigger_out_r <= '0;
      ch_sel_r      <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      if (state_r == STORE) begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
          if (ch_r == CH_W'(k + 1)) values_r[k*DATA_W +: DATA_W] <= cnt_r;
        end
      end
      trigger_out_r <= trig_s;
      ch_sel_r      <= ch_s;
      busy_r        <= (state_s != IDLE);
      done_r        <= (state_s == DONE);
    end
  end

  assign trigger_out = trigger_out_r;
  assign ch_sel      = ch_sel_r;
  assign values      = values_r;
  assign busy        = busy_r;
  assign done        = done_r;

`ifdef RANGE_MIN_TRACK_EN
  logic [CH_W-1:0]   min_index_r;
  logic [DATA_W-1:0] min_val_r;

  // running minimum; strict less-than keeps the lower channel on ties
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      min_index_r <= '0;
      min_val_r   <= SAT;
    end else if (state_r == IDLE && start) begin
      min_index_r <= '0;
      min_val_r   <= SAT;
    end else if (state_r == STORE && (min_index_r == '0 || cnt_r < min_val_r)) begin
      min_index_r <= ch_r;
      min_val_r   <= cnt_r;
    end
  end

  assign min_index = min_index_r;
`endif

endmodule

// File: tb/tb_ultrasound_range_collector.sv
// Randomized scoreboard bench for ultrasound_range_collector (small timing params).
module tb_ultrasound_range_collector;
  import ultrasound_range_collector_pkg::*;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 8;
  localparam int TICK   = 4;
  localparam int TRIG   = 10;
  localparam int GAPC   = 20;

  typedef struct packed {
    logic [NUM_CH*DATA_W-1:0] vals;
    logic [2:0]               min_idx;
  } exp_t;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     start = 1'b0;
  logic                     echo_in = 1'b0;
  logic [NUM_CH-1:0]        trigger_out;
  logic [2:0]               ch_sel;
  logic [NUM_CH*DATA_W-1:0] values;
  logic                     busy, done;
`ifdef RANGE_MIN_TRACK_EN
  logic [2:0]               min_index;
`endif

  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;
  int   scans_expected = 0;
  int   cur[NUM_CH];
  exp_t exp_q[$];

  ultrasound_range_collector #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TICK_DIV(TICK),
    .TRIG_CYCLES(TRIG), .GAP_CYCLES(GAPC)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .echo_in     (echo_in),
    .trigger_out (trigger_out),
    .ch_sel      (ch_sel),
    .values      (values),
    .busy        (busy),
    .done        (done)
`ifdef RANGE_MIN_TRACK_EN
    ,
    .min_index   (min_index)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: reading = ticks of echo, saturated; no echo -> saturation.
  function automatic exp_t model();
    exp_t e;
    int   r[NUM_CH];
    int   best;
    e = '0;
    best = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      r[k] = (cur[k] < 0 || cur[k] > int'(RANGE_SAT)) ? int'(RANGE_SAT) : cur[k];
      e.vals[k*DATA_W +: DATA_W] = DATA_W'(r[k]);
      if (r[k] < r[best]) best = k;
    end
    e.min_idx = 3'(best + 1);
    return e;
  endfunction

  task automatic wait_trigger(input int ch, input bit level, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (level ? (trigger_out != '0 && int'(ch_sel) == ch) : (trigger_out == '0)) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("trigger wait ch%0d level%0d", ch, level), ok, 1);
  endtask

  task automatic reset_check();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("reset trigger_out", trigger_out, 0);
    check("reset ch_sel", ch_sel, 0);
    check("reset values", values, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
`ifdef RANGE_MIN_TRACK_EN
    check("reset min_index", min_index, 0);
`endif
    echo_in = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // abort_ch != 0: drop reset while that channel is measuring.
  task automatic run_scan(input int abort_ch, input bit mid_start);
    bit ok;
    int hi;
    if (abort_ch == 0) begin
      exp_q.push_back(model());
      scans_expected++;
    end
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy after start", busy, 1);
    for (int ch = 1; ch <= NUM_CH; ch++) begin
      wait_trigger(ch, 1'b1, ok);
      if (!ok) return;
      wait_trigger(ch, 1'b0, ok);
      if (!ok) return;
      if (mid_start && ch == 2) begin
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
      if (cur[ch-1] >= 0) begin
        repeat ($urandom_range(1, 12)) @(negedge clock);
        echo_in = 1'b1;
        hi = cur[ch-1] * TICK + ((cur[ch-1] == 0) ? int'($urandom_range(1, TICK-1))
                                                  : int'($urandom_range(0, TICK-1)));
        if (ch == abort_ch) begin
          repeat (3 + 2 * TICK) @(negedge clock);
          reset_check();
          return;
        end
        for (int i = 0; i < hi; i++) begin
          @(negedge clock);
          if (int'(ch_sel) != ch) break;
        end
        echo_in = 1'b0;
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("scan completes", ok, 1);
  endtask

  // scoreboard monitor: every done pulse pops one expected scan
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          check("unexpected done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < NUM_CH; k++)
            check($sformatf("slot%0d", k + 1), values[k*DATA_W +: DATA_W], e.vals[k*DATA_W +: DATA_W]);
          check("busy during done", busy, 1);
`ifdef RANGE_MIN_TRACK_EN
          check("min_index", min_index, e.min_idx);
`endif
        end
      end
    end
  end

  // trigger monitor: one-hot on the selected channel, exactly TRIG cycles per pulse
  initial begin
    int run;
    bit bad;
    run = 0;
    bad = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        run = 0;
        bad = 1'b0;
      end else if (trigger_out != '0) begin
        run++;
        if (ch_sel == 3'd0 || trigger_out != (NUM_CH'(1) << (ch_sel - 3'd1))) bad = 1'b1;
      end else if (run != 0) begin
        check("trigger width", run, TRIG);
        check("trigger one-hot", bad, 0);
        run = 0;
        bad = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("init trigger_out", trigger_out, 0);
    check("init values", values, 0);
    check("init busy", busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    cur = '{1, 2, 3, 4, 5};
    run_scan(0, 1'b0);
    cur = '{7, 5, -1, 6, 7};
    run_scan(0, 1'b1);
    cur = '{int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
            int'($urandom_range(0, 20)), 300, int'($urandom_range(0, 20))};
    run_scan(0, 1'b0);
    cur = '{9, 2, 7, 2, 3};
    run_scan(0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < NUM_CH; k++)
        cur[k] = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 20));
      run_scan(0, 1'b0);
    end
    cur = '{3, 4, 5, 6, 7};
    run_scan(2, 1'b0);
    for (int k = 0; k < NUM_CH; k++) cur[k] = int'($urandom_range(0, 12));
    run_scan(0, 1'b0);

    repeat (5) @(negedge clock);
    check("done pulse count", done_count, scans_expected);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
